// File: rtl/spi_dpi_pkg.sv
// Shared types and constants for the spi_dpi SPI target model.
package spi_dpi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   localparam logic [7:0] IdleFill = 8'hFF;
   localparam int         ByteW    = 8;

endpackage

// File: rtl/spi_dpi_sync.sv
// Two-flop synchroniser with a configurable reset value.
module spi_dpi_sync #(
   parameter int           W      = 1,
   parameter logic [W-1:0] RstVal = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RstVal;
         sync_q <= RstVal;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/spi_dpi.sv
// Oversampling SPI mode-0 target: byte stream in/out plus OOB sideband.
// Optional logging of received bytes and underflows with SPI_DPI_LOG_EN.
module spi_dpi
   import spi_dpi_pkg::*;
#(
   parameter string ID       = "spi",
   parameter int    NDevices = 1,
   parameter int    DataW    = 1,
   parameter int    OOB_InW  = 1,
   parameter int    OOB_OutW = 1,
   localparam int   DevW     = $clog2(NDevices) + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                sck,
   input  logic [NDevices-1:0] cs,
   input  logic [DataW-1:0]    copi,
   output logic [DataW-1:0]    cipo,
   input  logic [OOB_InW-1:0]  oob_in,
   output logic [OOB_OutW-1:0] oob_out,
   output logic                rx_valid_o,
   output logic [7:0]          rx_data_o,
   output logic                rx_first_o,
   output logic [DevW-1:0]     rx_dev_o,
   output logic                frame_end_o,
   input  logic [7:0]          tx_data_i,
   input  logic                tx_valid_i,
   output logic                tx_ready_o,
   output logic [OOB_InW-1:0]  oob_q_o,
   input  logic                oob_wr_i,
   input  logic [OOB_OutW-1:0] oob_wdata_i
);

   logic                sck_s;
   logic [NDevices-1:0] cs_s;
   logic [DataW-1:0]    copi_s;
   logic [OOB_InW-1:0]  oob_s;

   spi_dpi_sync #(.W(1), .RstVal(1'b0)) u_sync_sck (
      .clk_i (clk_i), .rst_i (rst_i), .d (sck), .q (sck_s)
   );
   spi_dpi_sync #(.W(NDevices), .RstVal({NDevices{1'b1}})) u_sync_cs (
      .clk_i (clk_i), .rst_i (rst_i), .d (cs), .q (cs_s)
   );
   spi_dpi_sync #(.W(DataW), .RstVal({DataW{1'b0}})) u_sync_copi (
      .clk_i (clk_i), .rst_i (rst_i), .d (copi), .q (copi_s)
   );
   spi_dpi_sync #(.W(OOB_InW), .RstVal({OOB_InW{1'b0}})) u_sync_oob (
      .clk_i (clk_i), .rst_i (rst_i), .d (oob_in), .q (oob_s)
   );

   // Edge flags are registered together with the data lanes so that copi
   // is taken from the same sample that revealed the rising edge.
   logic             sck_d;
   logic             rise_q;
   logic             fall_q;
   logic [DataW-1:0] copi_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sck_d  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         copi_q <= '0;
      end else begin
         sck_d  <= sck_s;
         rise_q <= sck_s & ~sck_d;
         fall_q <= ~sck_s & sck_d;
         copi_q <= copi_s;
      end
   end

   logic            any_sel;
   logic [DevW-1:0] sel_dev;

   assign any_sel = ~&cs_s;

   always_comb begin
      sel_dev = '0;
      for (int i = NDevices - 1; i >= 0; i--) begin
         if (!cs_s[i]) sel_dev = DevW'(i);
      end
   end

   state_e state_q;
   state_e state_d;
   logic   frame_start;
   logic   frame_stop;
   logic   shift_in;
   logic   shift_out;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_sel)  state_d = ACTIVE;
         ACTIVE:  if (!any_sel) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      frame_start = 1'b0;
      frame_stop  = 1'b0;
      shift_in    = 1'b0;
      shift_out   = 1'b0;
      case (state_q)
         IDLE: frame_start = any_sel;
         ACTIVE: begin
            frame_stop = !any_sel;
            shift_in   = any_sel & rise_q;
            shift_out  = any_sel & fall_q;
         end
         default: ;
      endcase
   end

   logic [3:0]      bit_cnt;
   logic [3:0]      cnt_inc;
   logic            byte_done;
   logic [7:0]      rx_shift;
   logic [7:0]      rx_next;
   logic [7:0]      tx_shift;
   logic [7:0]      tx_fill;
   logic            tx_load;
   logic            skip_fall;
   logic            first_q;
   logic [DevW-1:0] dev_q;

   assign cnt_inc    = bit_cnt + 4'(DataW);
   assign byte_done  = shift_in && (cnt_inc == 4'(ByteW));
   assign rx_next    = (rx_shift << DataW) | ByteW'(copi_q);
   assign tx_load    = frame_start | byte_done;
   assign tx_fill    = tx_valid_i ? tx_data_i : IdleFill;
   assign tx_ready_o = tx_load & tx_valid_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bit_cnt     <= '0;
         rx_shift    <= '0;
         tx_shift    <= IdleFill;
         skip_fall   <= 1'b0;
         first_q     <= 1'b0;
         dev_q       <= '0;
         rx_valid_o  <= 1'b0;
         rx_data_o   <= '0;
         rx_first_o  <= 1'b0;
         frame_end_o <= 1'b0;
      end else begin
         rx_valid_o  <= 1'b0;
         rx_first_o  <= 1'b0;
         frame_end_o <= 1'b0;
         if (frame_start) begin
            bit_cnt   <= '0;
            tx_shift  <= tx_fill;
            skip_fall <= 1'b0;
            first_q   <= 1'b1;
            dev_q     <= sel_dev;
         end
         if (frame_stop) begin
            frame_end_o <= 1'b1;
            bit_cnt     <= '0;
            tx_shift    <= IdleFill;
         end
         if (shift_in) begin
            rx_shift <= rx_next;
            if (byte_done) begin
               bit_cnt    <= '0;
               rx_valid_o <= 1'b1;
               rx_data_o  <= rx_next;
               rx_first_o <= first_q;
               first_q    <= 1'b0;
               tx_shift   <= tx_fill;
               skip_fall  <= 1'b1;
            end else begin
               bit_cnt <= cnt_inc;
            end
         end
         // The falling edge right after a reload must keep the fresh MSBs.
         if (shift_out) begin
            if (skip_fall) skip_fall <= 1'b0;
            else           tx_shift  <= tx_shift << DataW;
         end
      end
   end

   assign cipo     = (state_q == ACTIVE) ? tx_shift[ByteW-1 -: DataW] : {DataW{1'b1}};
   assign rx_dev_o = dev_q;
   assign oob_q_o  = oob_s;

   always_ff @(posedge clk_i) begin
      if (rst_i)         oob_out <= '0;
      else if (oob_wr_i) oob_out <= oob_wdata_i;
   end

`ifdef SPI_DPI_LOG_EN
   always_ff @(posedge clk_i) begin
      if (!rst_i && byte_done)
         $display("%s: dev %0d rx 0x%02h", ID, dev_q, rx_next);
      if (!rst_i && tx_load && !tx_valid_i)
         $display("%s: dev %0d tx underflow, sending 0x%02h", ID,
                  frame_start ? sel_dev : dev_q, IdleFill);
   end
`else
   // Logging disabled: no display statements are elaborated.
`endif

endmodule

// File: tb/tb_spi_dpi.sv
// Self-checking bench for spi_dpi: randomized frames against a byte-level model.
module tb_spi_dpi;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: two chip selects, single lane.
   logic       sck = 1'b0;
   logic [1:0] cs = 2'b11;
   logic [0:0] copi = '0;
   logic [0:0] cipo;
   logic [1:0] oob_in = '0;
   logic [1:0] oob_out;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_first;
   logic [1:0] rx_dev;
   logic       frame_end;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [1:0] oob_q;
   logic       oob_wr = 1'b0;
   logic [1:0] oob_wdata = '0;

   // Instance B: single chip select, four lanes.
   logic       sck4 = 1'b0;
   logic [0:0] cs4 = 1'b1;
   logic [3:0] copi4 = '0;
   logic [3:0] cipo4;
   logic [0:0] oob_in4 = '0;
   logic [0:0] oob_out4;
   logic       rx_valid4;
   logic [7:0] rx_data4;
   logic       rx_first4;
   logic [0:0] rx_dev4;
   logic       frame_end4;
   logic [7:0] tx_data4 = '0;
   logic       tx_valid4 = 1'b0;
   logic       tx_ready4;
   logic [0:0] oob_q4;

   spi_dpi #(.ID("spi_a"), .NDevices(2), .DataW(1), .OOB_InW(2), .OOB_OutW(2)) u_dut (
      .clk_i (clk), .rst_i (rst), .sck (sck), .cs (cs), .copi (copi), .cipo (cipo),
      .oob_in (oob_in), .oob_out (oob_out), .rx_valid_o (rx_valid), .rx_data_o (rx_data),
      .rx_first_o (rx_first), .rx_dev_o (rx_dev), .frame_end_o (frame_end),
      .tx_data_i (tx_data), .tx_valid_i (tx_valid), .tx_ready_o (tx_ready),
      .oob_q_o (oob_q), .oob_wr_i (oob_wr), .oob_wdata_i (oob_wdata)
   );

   spi_dpi #(.ID("spi_b"), .NDevices(1), .DataW(4), .OOB_InW(1), .OOB_OutW(1)) u_dut4 (
      .clk_i (clk), .rst_i (rst), .sck (sck4), .cs (cs4), .copi (copi4), .cipo (cipo4),
      .oob_in (oob_in4), .oob_out (oob_out4), .rx_valid_o (rx_valid4), .rx_data_o (rx_data4),
      .rx_first_o (rx_first4), .rx_dev_o (rx_dev4), .frame_end_o (frame_end4),
      .tx_data_i (tx_data4), .tx_valid_i (tx_valid4), .tx_ready_o (tx_ready4),
      .oob_q_o (oob_q4), .oob_wr_i (1'b0), .oob_wdata_i (1'b0)
   );

   int checks = 0;
   int failures = 0;
   int frame_end_seen = 0;
   int frame_end_exp = 0;

   logic [10:0] exp_q[$];   // {dev[1:0], first, data[7:0]}
   logic [7:0]  exp4_q[$];
   logic [7:0]  tx_src_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Host transmit source: presents the head of tx_src_q, pops on handshake.
   initial begin
      logic take;
      forever begin
         @(negedge clk);
         take = tx_valid && tx_ready;
         @(posedge clk);
         if (take && tx_src_q.size() > 0) void'(tx_src_q.pop_front());
         #1;
         tx_valid = (tx_src_q.size() > 0);
         tx_data  = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'h00;
      end
   end

   // Monitor: compares every received byte against the scoreboard queue.
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge clk);
         if (rx_valid) begin
            if (exp_q.size() == 0) begin
               check("rx_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(e[7:0]));
               check("rx_first", 32'(rx_first), 32'(e[8]));
               check("rx_dev", 32'(rx_dev), 32'(e[10:9]));
            end
         end
         if (frame_end) frame_end_seen++;
         if (rx_valid4) begin
            if (exp4_q.size() == 0) check("rx4_unexpected", 32'd1, 32'd0);
            else check("rx4_data", 32'(rx_data4), 32'(exp4_q.pop_front()));
         end
      end
   end

   // One frame on instance A; byte k reads back the k-th queued host byte
   // if one exists, otherwise the 0xFF idle fill.
   task automatic spi_frame(input logic [1:0] csv, input int nbytes, input int ntx);
      logic [7:0] txb[$];
      logic [7:0] d;
      logic [7:0] rd;
      logic [1:0] dev;
      dev = (csv[0] == 1'b0) ? 2'd0 : 2'd1;
      tx_src_q.delete();
      for (int k = 0; k < ntx; k++) begin
         d = 8'($urandom);
         txb.push_back(d);
         tx_src_q.push_back(d);
      end
      cyc(2);
      cs = csv;
      cyc(6);
      for (int b = 0; b < nbytes; b++) begin
         d = 8'($urandom);
         exp_q.push_back({dev, (b == 0), d});
         rd = '0;
         for (int i = 7; i >= 0; i--) begin
            copi[0] = d[i];
            cyc(6);
            rd = {rd[6:0], cipo[0]};
            sck = 1'b1;
            cyc(6);
            sck = 1'b0;
         end
         check("cipo_read", 32'(rd), (b < ntx) ? 32'(txb[b]) : 32'hFF);
      end
      cyc(6);
      cs = 2'b11;
      frame_end_exp++;
      cyc(10);
      check("cipo_idle", 32'(cipo), 32'd1);
      tx_src_q.delete();
   endtask

   task automatic spi_partial(input int nbits);
      cs = 2'b10;
      cyc(6);
      for (int i = 0; i < nbits; i++) begin
         copi[0] = 1'($urandom);
         cyc(6);
         sck = 1'b1;
         cyc(6);
         sck = 1'b0;
      end
      cyc(6);
      cs = 2'b11;
      frame_end_exp++;
      cyc(10);
   endtask

   task automatic spi4_byte(input logic [7:0] d, input logic [7:0] txv);
      logic [7:0] rd;
      tx_data4  = txv;
      tx_valid4 = 1'b1;
      cyc(2);
      cs4 = 1'b0;
      cyc(6);
      exp4_q.push_back(d);
      rd = '0;
      for (int n = 1; n >= 0; n--) begin
         copi4 = (n == 1) ? d[7:4] : d[3:0];
         cyc(6);
         rd = {rd[3:0], cipo4};
         sck4 = 1'b1;
         cyc(6);
         sck4 = 1'b0;
      end
      check("cipo4_read", 32'(rd), 32'(txv));
      cyc(6);
      cs4 = 1'b1;
      tx_valid4 = 1'b0;
      cyc(10);
      check("cipo4_idle", 32'(cipo4), 32'hF);
   endtask

   initial begin
      logic [1:0] v;
      logic [1:0] old;
      int         cnt;
      cyc(5);
      rst = 1'b0;
      cyc(3);
      check("rst_cipo", 32'(cipo), 32'd1);
      check("rst_oob_out", 32'(oob_out), 32'd0);
      check("rst_oob_q", 32'(oob_q), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_frame_end", 32'(frame_end), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_rx_dev", 32'(rx_dev), 32'd0);

      // Sideband write/hold and input synchroniser latency.
      oob_wdata = 2'b01;
      oob_wr = 1'b1;
      cyc(1);
      oob_wr = 1'b0;
      oob_wdata = 2'b10;
      check("oob_out_wr", 32'(oob_out), 32'd1);
      cyc(3);
      check("oob_out_hold", 32'(oob_out), 32'd1);
      for (int t = 0; t < 4; t++) begin
         old = oob_in;
         v = 2'($urandom) ^ 2'b01;
         oob_in = v;
         cyc(1);
         check("oob_q_lag", 32'(oob_q), 32'(old));
         cyc(1);
         check("oob_q_sync", 32'(oob_q), 32'(v));
      end

      // Directed frames on A, then randomized ones.
      spi_frame(2'b10, 1, 1);
      spi_frame(2'b10, 2, 0);
      spi_partial(5);
      spi_frame(2'b01, 1, 1);
      spi_frame(2'b00, 2, 2);
      for (int r = 0; r < 8; r++) begin
         cnt = $urandom_range(1, 3);
         spi_frame(2'($urandom_range(0, 2)), cnt, $urandom_range(0, cnt));
      end

      // Four-lane instance.
      spi4_byte(8'hC7, 8'h5A);
      spi4_byte(8'($urandom), 8'($urandom));

      for (int c = 0; c < 200 && (exp_q.size() > 0 || exp4_q.size() > 0); c++) cyc(1);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("exp4_q_drained", 32'(exp4_q.size()), 32'd0);
      check("frame_end_count", 32'(frame_end_seen), 32'(frame_end_exp));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
